// File: rtl/obi_sbr_pkg.sv
// Shared constants and response type for the OBI subordinate RAM.
// Responses carry a fixed-width data field; the RAM uses only its low DATA_WIDTH bits.
package obi_sbr_pkg;

  localparam int unsigned RSP_MAX_DW = 128;
  localparam logic [31:0] ERR_DATA = 32'hBADCAB1E;

  typedef struct packed {
    logic                  err;
    logic [RSP_MAX_DW-1:0] rdata;
  } obi_rsp_t;

  // ERR_DATA repeated across the whole field so any DATA_WIDTH slice sees the pattern
  function automatic logic [RSP_MAX_DW-1:0] err_pattern();
    logic [RSP_MAX_DW-1:0] p;
    p = '0;
    for (int i = 0; i < RSP_MAX_DW; i++) begin
      p[i] = ERR_DATA[i % 32];
    end
    return p;
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue: register-based circular buffer with occupancy count.
// Storage is not reset; only pointers and count are, so stale slots are never visible as valid.
module obi_resp_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = slots[rptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      slots[wptr] <= data_i;
    end
  end

  // Pointers wrap explicitly at DEPTH so non-power-of-two depths lose nothing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= next_ptr(wptr);
      end
      if (do_pop) begin
        rptr <= next_ptr(rptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o));

  a_no_pop_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && empty_o));

endmodule

// File: rtl/obi_sbr_ram.sv
// OBI subordinate backed by a word-addressed RAM; every accepted request queues one response.
// Read data is captured at the accept edge, so later writes never alter a queued read.
module obi_sbr_ram
  import obi_sbr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
  localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);
  localparam logic [IDX_W:0] MEM_LIMIT = (IDX_W + 1)'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0]      word_idx;
  logic [MEM_AW-1:0]     mem_addr;
  logic                  in_range;
  logic                  accept;
  logic                  pop;
  logic [DATA_WIDTH-1:0] be_mask;
  obi_rsp_t              rsp_push;
  obi_rsp_t              head_rsp;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused_bits;

  assign word_idx = obi_addr_i[ADDR_WIDTH-1:OFFS_W];
  assign in_range = ({1'b0, word_idx} < MEM_LIMIT);
  assign mem_addr = word_idx[MEM_AW-1:0];

  assign obi_gnt_o = (fifo_count < CNT_W'(MAX_OUTST));
  assign accept    = obi_req_i && obi_gnt_o;
  assign pop       = obi_rvalid_o && obi_rready_i;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      be_mask[b*8 +: 8] = {8{obi_be_i[b]}};
    end
  end

  // Out-of-range requests of either direction answer with the error pattern
  always_comb begin
    rsp_push = '0;
    if (!in_range) begin
      rsp_push.err   = 1'b1;
      rsp_push.rdata = err_pattern();
    end else if (!obi_we_i) begin
      rsp_push.rdata[DATA_WIDTH-1:0] = mem[mem_addr] & be_mask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && obi_we_i && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (obi_be_i[b]) begin
          mem[mem_addr][b*8 +: 8] <= obi_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  obi_resp_fifo #(
    .WIDTH ($bits(obi_rsp_t)),
    .DEPTH (MAX_OUTST)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .push_i  (accept),
    .data_i  (rsp_push),
    .pop_i   (pop),
    .data_o  (head_rsp),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Response outputs are forced to zero when nothing is queued, including under reset
  assign obi_rvalid_o = !fifo_empty;
  assign obi_rdata_o  = fifo_empty ? '0 : head_rsp.rdata[DATA_WIDTH-1:0];
  assign obi_err_o    = !fifo_empty && head_rsp.err;

  assign unused_bits = ^{head_rsp.rdata, fifo_full};

  if (OFFS_W > 0) begin : g_offs
    logic unused_offs;
    assign unused_offs = ^obi_addr_i[OFFS_W-1:0];
  end

  a_gnt_low_when_full : assert property (@(posedge clk_i) disable iff (!reset_ni)
    fifo_full |-> !obi_gnt_o);

endmodule

// File: tb/tb_obi_sbr_ram.sv
// Self-checking bench for obi_sbr_ram: directed scenarios plus random traffic
// compared against a transaction-level model (word array + expected-response queue).
module tb_obi_sbr_ram;

  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned MEM_WORDS = 256;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_rsp_t;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic        obi_rready_i;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [MEM_WORDS];
  exp_rsp_t    rsp_q[$];

  obi_sbr_ram #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_WORDS  (MEM_WORDS),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rready_i (obi_rready_i),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Model of one accepted request: reads see memory as it stands, writes merge enabled lanes
  function automatic void modelAccept(input logic we, input logic [31:0] addr,
                                      input logic [3:0] be, input logic [31:0] wdata);
    exp_rsp_t r;
    int unsigned idx;
    idx = addr / 4;
    r.d = 32'h0;
    r.e = 1'b0;
    if (idx >= MEM_WORDS) begin
      r.d = 32'hBADCAB1E;
      r.e = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b] && we) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        if (be[b] && !we) r.d[8*b +: 8] = ref_mem[idx][8*b +: 8];
      end
    end
    rsp_q.push_back(r);
  endfunction

  // One bus cycle: drive at negedge, check outputs against the model, advance model at posedge
  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic rr, output logic accepted);
    logic     exp_gnt;
    logic     do_pop;
    exp_rsp_t head;
    @(negedge clk_i);
    obi_req_i    = req;
    obi_we_i     = we;
    obi_addr_i   = addr;
    obi_be_i     = be;
    obi_wdata_i  = wdata;
    obi_rready_i = rr;
    #1;
    exp_gnt = (rsp_q.size() < MAX_OUTST);
    head.d  = 32'h0;
    head.e  = 1'b0;
    if (rsp_q.size() > 0) head = rsp_q[0];
    checkOutput("gnt",    {31'b0, obi_gnt_o},    {31'b0, exp_gnt});
    checkOutput("rvalid", {31'b0, obi_rvalid_o}, {31'b0, rsp_q.size() > 0});
    checkOutput("rdata",  obi_rdata_o,           head.d);
    checkOutput("err",    {31'b0, obi_err_o},    {31'b0, head.e});
    do_pop   = rr && (rsp_q.size() > 0);
    accepted = req && exp_gnt;
    @(posedge clk_i);
    if (do_pop) void'(rsp_q.pop_front());
    if (accepted) modelAccept(we, addr, be, wdata);
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic rr);
    logic acc;
    applyStimulus(1'b1, 1'b1, addr, be, wdata, rr, acc);
  endtask

  task automatic busRead(input logic [31:0] addr, input logic [3:0] be, input logic rr);
    logic acc;
    applyStimulus(1'b1, 1'b0, addr, be, 32'h0, rr, acc);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, rr, acc);
  endtask

  // Directed check of the head response shortly after an accept edge
  task automatic peek(input string tag, input logic [31:0] exp_d, input logic exp_e);
    #2;
    checkOutput({tag, "_rvalid"}, {31'b0, obi_rvalid_o}, 32'd1);
    checkOutput({tag, "_rdata"},  obi_rdata_o,           exp_d);
    checkOutput({tag, "_err"},    {31'b0, obi_err_o},    {31'b0, exp_e});
  endtask

  initial begin
    logic acc;
    int   tries;

    obi_req_i    = 1'b0;
    obi_we_i     = 1'b0;
    obi_addr_i   = 32'h0;
    obi_be_i     = 4'h0;
    obi_wdata_i  = 32'h0;
    obi_rready_i = 1'b1;
    reset_ni     = 1'b1;
    #2 reset_ni  = 1'b0;
    #1;
    checkOutput("rst_gnt",    {31'b0, obi_gnt_o},    32'd1);
    checkOutput("rst_rvalid", {31'b0, obi_rvalid_o}, 32'd0);
    checkOutput("rst_rdata",  obi_rdata_o,           32'd0);
    checkOutput("rst_err",    {31'b0, obi_err_o},    32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    $display("[TB] preloading words 0..15 over the bus");
    for (int i = 0; i < 16; i++) begin
      busWrite(32'(i * 4), 4'hF, {8'(i), 8'hC3, 8'(i * 3), 8'h5A}, 1'b1);
    end
    busWrite(32'h4, 4'hF, 32'hDA7A5EAD, 1'b1);
    busWrite(32'hC, 4'hF, 32'h33333333, 1'b1);

    $display("[TB] basic read");
    busRead(32'h4, 4'hF, 1'b1);
    peek("read_w1", 32'hDA7A5EAD, 1'b0);

    $display("[TB] byte lanes");
    busWrite(32'hF, 4'b1000, 32'h1337C0DE, 1'b1);
    busRead(32'hC, 4'hF, 1'b1);
    peek("lane_w3", 32'h13333333, 1'b0);
    busWrite(32'h8, 4'hF, 32'h1337C0DE, 1'b1);
    busRead(32'hA, 4'b1100, 1'b1);
    peek("lane_rd", 32'h13370000, 1'b0);
    busWrite(32'h8, 4'b0000, 32'hFFFFFFFF, 1'b1);
    peek("be0_wr", 32'h0, 1'b0);
    busRead(32'h8, 4'hF, 1'b1);
    peek("be0_keep", 32'h1337C0DE, 1'b0);

    $display("[TB] out-of-range accesses");
    busRead(32'h400, 4'hF, 1'b1);
    peek("oor_rd", 32'hBADCAB1E, 1'b1);
    busWrite(32'h400, 4'hF, 32'hFFFFFFFF, 1'b1);
    peek("oor_wr", 32'hBADCAB1E, 1'b1);
    busRead(32'h0, 4'hF, 1'b1);
    peek("oor_noalias", 32'h00C3005A, 1'b0);
    idle(1, 1'b1);

    $display("[TB] backpressure with full response queue");
    busRead(32'h10, 4'hF, 1'b0);
    busRead(32'h14, 4'hF, 1'b0);
    #2;
    checkOutput("full_gnt", {31'b0, obi_gnt_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h18, 4'hF, 32'h0, 1'b0, acc);
    checkOutput("full_noacc", {31'b0, acc}, 32'd0);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 10) begin
      applyStimulus(1'b1, 1'b0, 32'h18, 4'hF, 32'h0, 1'b1, acc);
      tries++;
    end
    checkOutput("third_accepted", {31'b0, acc}, 32'd1);
    idle(3, 1'b1);

    $display("[TB] ordering between reads and writes");
    busWrite(32'h8, 4'hF, 32'hFEED0008, 1'b1);
    busRead(32'h8, 4'hF, 1'b1);
    peek("raw", 32'hFEED0008, 1'b0);
    idle(1, 1'b1);
    busRead(32'h10, 4'hF, 1'b0);
    busWrite(32'h10, 4'hF, 32'h0A0B0C0D, 1'b0);
    peek("queued_old", 32'h04C30C5A, 1'b0);
    idle(3, 1'b1);
    busRead(32'h10, 4'hF, 1'b1);
    peek("queued_new", 32'h0A0B0C0D, 1'b0);
    idle(1, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      logic [31:0] addr;
      addr = ($urandom_range(0, 15) == 0) ? 32'h400 + 32'($urandom_range(0, 63))
                                          : 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), addr,
                    4'($urandom), $urandom, 1'($urandom_range(0, 2) != 0), acc);
    end
    idle(3, 1'b1);

    $display("[TB] reset with responses pending");
    busWrite(32'h1C, 4'hF, 32'hC0FFEE77, 1'b0);
    busRead(32'h1C, 4'hF, 1'b0);
    #3;
    obi_req_i = 1'b0;
    reset_ni  = 1'b0;
    #1;
    checkOutput("midrst_rvalid", {31'b0, obi_rvalid_o}, 32'd0);
    checkOutput("midrst_gnt",    {31'b0, obi_gnt_o},    32'd1);
    checkOutput("midrst_rdata",  obi_rdata_o,           32'd0);
    checkOutput("midrst_err",    {31'b0, obi_err_o},    32'd0);
    rsp_q.delete();
    @(negedge clk_i);
    reset_ni = 1'b1;
    busRead(32'h1C, 4'hF, 1'b1);
    peek("persist", 32'hC0FFEE77, 1'b0);
    idle(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
